// File: rtl/ground_pkg.sv
// rtl/ground_pkg.sv - shared ground strip geometry defaults and scroller state enum
package ground_pkg;

  localparam int GX0_DEF = 50;
  localparam int GY0_DEF = 400;
  localparam int GH_DEF  = 10;
  localparam int GW_DEF  = 700;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } gs_state_t;

endpackage

// File: rtl/scroll_ctr.sv
// rtl/scroll_ctr.sv - scroll offset accumulator with single-subtract wrap at GW
module scroll_ctr
  import ground_pkg::*;
#(
  parameter int GW = GW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] step,
  output logic [9:0] offset
);

  localparam logic [10:0] GW11 = 11'(GW);

  logic [10:0] sum;
  logic [10:0] wrapped;

  // offset + step never reaches 2*GW for steps 1..8, so one subtract is enough
  always_comb begin
    sum     = {1'b0, offset} + {7'd0, step};
    wrapped = (sum >= GW11) ? (sum - GW11) : sum;
  end

  // clear wins over advance; both are suppressed while in reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset <= '0;
    end else if (clr) begin
      offset <= '0;
    end else if (en) begin
      offset <= 10'(wrapped);
    end
  end

endmodule

// File: rtl/ground_scroller.sv
// rtl/ground_scroller.sv - scrolling ground strip: run/freeze FSM plus two-stage pixel pipeline
module ground_scroller
  import ground_pkg::*;
#(
  parameter int GX0 = GX0_DEF,
  parameter int GY0 = GY0_DEF,
  parameter int GH  = GH_DEF,
  parameter int GW  = GW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [10:0]   hc,
  input  logic [10:0]   vc,
  input  logic [GW-1:0] line_row,
  input  logic          frame_tick,
  input  logic          start,
  input  logic          crash,
  input  logic [2:0]    speed,
  output logic          ground_px,
  output logic          ground_en,
  output logic [9:0]    offset
);

  localparam logic [10:0] X_LO = 11'(GX0);
  localparam logic [10:0] X_HI = 11'(GX0 + GW);
  localparam logic [10:0] Y_LO = 11'(GY0);
  localparam logic [10:0] Y_HI = 11'(GY0 + GH);
  localparam logic [10:0] GW11 = 11'(GW);
  localparam logic [9:0]  LAST = 10'(GW - 1);

  gs_state_t state, state_nxt;
  logic      adv, clr;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state; advance only while already running so the entry tick is ignored
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (crash) state_nxt = FROZEN;
        else       adv = frame_tick;
      end
      FROZEN: begin
        if (start && !crash) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  scroll_ctr #(.GW(GW)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (adv),
    .clr    (clr),
    .step   ({1'b0, speed} + 4'd1),
    .offset (offset)
  );

  logic          in_strip;
  logic [10:0]   rel, sum, idx_wide;
  logic [9:0]    idx;
  logic          in_strip_q;
  logic [9:0]    idx_q;
  logic [GW-1:0] row_q;
  logic [9:0]    sel;

  // stage 1 inputs: strip test and pattern index; idx forced to 0 outside the strip
  always_comb begin
    in_strip = (hc >= X_LO) && (hc < X_HI) && (vc >= Y_LO) && (vc < Y_HI);
    rel      = hc - X_LO;
    sum      = rel + {1'b0, offset};
    idx_wide = (sum >= GW11) ? (sum - GW11) : sum;
    idx      = in_strip ? 10'(idx_wide) : 10'd0;
    sel      = LAST - idx_q;
  end

  // stage 1 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_strip_q <= 1'b0;
      idx_q      <= '0;
      row_q      <= '0;
    end else begin
      in_strip_q <= in_strip;
      idx_q      <= idx;
      row_q      <= line_row;
    end
  end

  // stage 2 register: pixel is gated by the strip flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ground_en <= 1'b0;
      ground_px <= 1'b0;
    end else begin
      ground_en <= in_strip_q;
      ground_px <= in_strip_q & row_q[sel];
    end
  end

endmodule

// File: tb/tb_ground_scroller.sv
// tb/tb_ground_scroller.sv - directed self-checking bench for ground_scroller
module tb_ground_scroller;

  localparam int GW = 700;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   hc, vc;
  logic [GW-1:0] line_row;
  logic          frame_tick, start, crash;
  logic [2:0]    speed;
  logic          ground_px, ground_en;
  logic [9:0]    offset;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ground_scroller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hc         (hc),
    .vc         (vc),
    .line_row   (line_row),
    .frame_tick (frame_tick),
    .start      (start),
    .crash      (crash),
    .speed      (speed),
    .ground_px  (ground_px),
    .ground_en  (ground_en),
    .offset     (offset)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ftick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [GW-1:0] row);
    hc = h; vc = v; line_row = row;
    tick();
    tick();
  endtask

  logic [GW-1:0] r;

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; crash = 1'b0; speed = 3'd0;
    hc = 11'd60; vc = 11'd405; line_row = '1;

    // reset with an in-strip, all-ones pattern: outputs must stay low
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_px", 32'(ground_px), 32'd0);
    end
    check("rst_en", 32'(ground_en), 32'd0);
    check("rst_off", 32'(offset), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores frame_tick
    ftick();
    check("idle_hold", 32'(offset), 32'd0);

    // pixel pipeline at offset 0
    r = '0; r[GW-1] = 1'b1;
    hc = 11'd50; vc = 11'd400; line_row = r;
    tick();
    hc = 11'd49; line_row = '1;
    tick();
    check("lat2_px", 32'(ground_px), 32'd1);
    check("lat2_en", 32'(ground_en), 32'd1);
    pix(11'd51, 11'd400, r);
    check("idx1_px", 32'(ground_px), 32'd0);
    pix(11'd49, 11'd400, '1);
    check("left_en", 32'(ground_en), 32'd0);
    check("left_px", 32'(ground_px), 32'd0);
    pix(11'd50, 11'd410, '1);
    check("bot_en", 32'(ground_en), 32'd0);
    pix(11'd749, 11'd409, '1);
    check("corner_en", 32'(ground_en), 32'd1);
    check("corner_px", 32'(ground_px), 32'd1);
    pix(11'd750, 11'd400, '1);
    check("right_en", 32'(ground_en), 32'd0);

    // start with a simultaneous frame_tick does not advance
    start = 1'b1; frame_tick = 1'b1;
    tick();
    start = 1'b0; frame_tick = 1'b0;
    check("entry_tick", 32'(offset), 32'd0);
    for (int i = 0; i < 3; i++) ftick();
    check("run3", 32'(offset), 32'd3);

    // new offset applies to subsequent pixels: idx = 0+3
    r = '0; r[GW-1-3] = 1'b1;
    pix(11'd50, 11'd400, r);
    check("off3_px", 32'(ground_px), 32'd1);

    // climb to 695, then wrap with step 8
    speed = 3'd7;
    for (int i = 0; i < 86; i++) ftick();
    check("off691", 32'(offset), 32'd691);
    speed = 3'd3;
    ftick();
    check("off695", 32'(offset), 32'd695);
    speed = 3'd7;
    ftick();
    check("wrap3", 32'(offset), 32'd3);
    speed = 3'd6;
    ftick();
    check("off10", 32'(offset), 32'd10);

    // index wrap: hc=745 -> (695+10) mod 700 = 5 -> bit 694
    r = '0; r[694] = 1'b1;
    pix(11'd745, 11'd400, r);
    check("iwrap_hit", 32'(ground_px), 32'd1);
    r = '0; r[695] = 1'b1;
    pix(11'd745, 11'd400, r);
    check("iwrap_miss", 32'(ground_px), 32'd0);

    // crash beats start; frozen holds offset
    crash = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) ftick();
    check("frozen5", 32'(offset), 32'd10);
    start = 1'b1;
    ftick();
    check("frozen_both", 32'(offset), 32'd10);
    crash = 1'b0;
    tick();
    start = 1'b0;
    check("restart_clr", 32'(offset), 32'd0);
    speed = 3'd0;
    ftick();
    check("restart_run", 32'(offset), 32'd1);

    // reach 200, then a one-cycle reset pulse
    speed = 3'd7;
    for (int i = 0; i < 24; i++) ftick();
    speed = 3'd6;
    ftick();
    check("off200", 32'(offset), 32'd200);
    hc = 11'd60; vc = 11'd405; line_row = '1;
    tick();
    tick();
    check("pre_rst_px", 32'(ground_px), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_off", 32'(offset), 32'd0);
    check("mid_rst_px", 32'(ground_px), 32'd0);
    check("mid_rst_en", 32'(ground_en), 32'd0);
    hc = 11'd0; vc = 11'd0;
    tick();
    check("post_rst_px", 32'(ground_px), 32'd0);
    for (int i = 0; i < 3; i++) ftick();
    check("post_rst_idle", 32'(offset), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    speed = 3'd0;
    ftick();
    check("post_rst_run", 32'(offset), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
